// File: rtl/req_enc_pkg.sv
// req_enc_pkg: shared types and constants for the 4-to-2 request encoder
package req_enc_pkg;
    localparam int NUM_REQ = 4;
    typedef logic [1:0] code_t;
    typedef logic [NUM_REQ-1:0] req_t;
    typedef enum logic {IDLE, OUT} state_t;
endpackage

// File: rtl/req_encoder4_if.sv
// req_encoder4_if: request capture and code handshake bundle
interface req_encoder4_if;
    import req_enc_pkg::*;
    logic en;
    req_t req;
    logic ready;
    code_t code;
    logic valid;
    req_t pending;
    logic busy;
    modport master (output en, req, ready, input code, valid, pending, busy);
    modport slave (input en, req, ready, output code, valid, pending, busy);
endinterface

// File: rtl/req_encoder4_prio_enc4.sv
// prio_enc4: picks one set bit; fixed priority (bit 3 first) or upward wrap from start.
// ROUND_ROBIN_EN selects the wrap search; otherwise start is ignored.
module prio_enc4
    import req_enc_pkg::*;
(
    input  req_t  vec,
    input  code_t start,
    output logic  found,
    output code_t idx
);
`ifdef ROUND_ROBIN_EN
    // Walk the search order backwards so the earliest hit is the last written.
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (vec[start + code_t'(k)]) begin
                found = 1'b1;
                idx = start + code_t'(k);
            end
    end
`else
    logic unused_start;
    assign unused_start = ^start;
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (vec[k]) begin
                found = 1'b1;
                idx = code_t'(k);
            end
    end
`endif
endmodule

// File: rtl/req_encoder4.sv
// req_encoder4: collects request lines and issues one 2-bit code per handshake.
// ROUND_ROBIN_EN switches selection from fixed priority to round-robin.
module req_encoder4
    import req_enc_pkg::*;
(
    input logic clk,
    input logic rst,
    req_encoder4_if.slave bus
);
    state_t state, state_next;
    code_t  code_q, idx, start;
    req_t   pend_q, clr;
    logic   found, load;

`ifdef ROUND_ROBIN_EN
    code_t ptr;
    always_ff @(posedge clk)
        ptr <= rst ? 2'd3 : (load && found) ? idx : ptr;
    assign start = ptr + 2'd1;
`else
    assign start = '0;
`endif

    prio_enc4 u_prio (.vec(pend_q), .start(start), .found(found), .idx(idx));

    assign load = (state == IDLE) || bus.ready;
    assign clr = (load && found) ? req_t'(1) << idx : '0;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;

    always_comb
        state_next = load ? (found ? OUT : IDLE) : state;

    // A req bit arriving as its pending bit retires wins, so it is granted again.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            pend_q <= '0;
        end else begin
            code_q <= (load && found) ? idx : code_q;
            pend_q <= (pend_q & ~clr) | (bus.en ? bus.req : '0);
        end
    end

    always_comb begin
        bus.valid = state == OUT;
        bus.code = code_q;
        bus.pending = pend_q;
        bus.busy = (state == OUT) | (|pend_q);
    end
endmodule

// File: tb/tb_req_encoder4.sv
// tb_req_encoder4: directed literal checks plus randomized traffic against a per-cycle model.
module tb_req_encoder4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0, total = 0;
    bit chk_on = 1'b0;

    req_encoder4_if bus ();
    req_encoder4 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model state: which indices await service, and what sits in the output slot.
    int m_pend [4];
    bit m_valid;
    int m_code, m_ptr, m_sel;

    function automatic logic [3:0] m_pend_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_pend[i] != 0;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
            m_valid = 0;
            m_code = 0;
            m_ptr = 3;
        end else begin
            if (!m_valid || bus.ready) begin
                m_sel = -1;
`ifdef ROUND_ROBIN_EN
                for (int j = 1; j <= 4; j++)
                    if (m_sel < 0 && m_pend[(m_ptr + j) % 4] != 0) m_sel = (m_ptr + j) % 4;
`else
                for (int i = 3; i >= 0; i--)
                    if (m_sel < 0 && m_pend[i] != 0) m_sel = i;
`endif
                if (m_sel >= 0) begin
                    m_pend[m_sel] = 0;
                    m_code = m_sel;
                    m_ptr = m_sel;
                    m_valid = 1;
                end else
                    m_valid = 0;
            end
            for (int i = 0; i < 4; i++)
                if (bus.en && bus.req[i]) m_pend[i] = 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk)
        if (chk_on) begin
            chk("model_code", int'(bus.code), m_code);
            chk("model_valid", int'(bus.valid), int'(m_valid));
            chk("model_pending", int'(bus.pending), int'(m_pend_vec()));
            chk("model_busy", int'(bus.busy), int'(m_valid || m_pend_vec() != 0));
        end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic lit(input string name, input int code, input int valid, input int pend);
        chk({name, "_code"}, int'(bus.code), code);
        chk({name, "_valid"}, int'(bus.valid), valid);
        chk({name, "_pending"}, int'(bus.pending), pend);
        chk({name, "_busy"}, int'(bus.busy), int'(valid != 0 || pend != 0));
    endtask

    initial begin
        bus.en = 1'b0;
        bus.req = 4'b0;
        bus.ready = 1'b0;
        do_reset();
        chk_on = 1'b1;
        lit("reset", 0, 0, 4'b0000);
        bus.ready = 1'b1;
        cyc();
        lit("idle_ready", 0, 0, 4'b0000);

        bus.en = 1'b1;
        bus.req = 4'b0100;
        cyc();
        lit("single_pend", 0, 0, 4'b0100);
        bus.req = 4'b0;
        cyc();
        lit("single_grant", 2, 1, 4'b0000);
        cyc();
        lit("single_done", 2, 0, 4'b0000);

        do_reset();
        bus.req = 4'b1011;
        cyc();
        lit("multi_pend", 0, 0, 4'b1011);
        bus.req = 4'b0;
`ifdef ROUND_ROBIN_EN
        cyc(); lit("multi_g1", 0, 1, 4'b1010);
        cyc(); lit("multi_g2", 1, 1, 4'b1000);
        cyc(); lit("multi_g3", 3, 1, 4'b0000);
        cyc(); lit("multi_done", 3, 0, 4'b0000);
`else
        cyc(); lit("multi_g1", 3, 1, 4'b0011);
        cyc(); lit("multi_g2", 1, 1, 4'b0001);
        cyc(); lit("multi_g3", 0, 1, 4'b0000);
        cyc(); lit("multi_done", 0, 0, 4'b0000);
`endif

        do_reset();
        bus.ready = 1'b0;
        bus.req = 4'b0011;
        cyc();
        bus.req = 4'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
`ifdef ROUND_ROBIN_EN
            lit("bp_hold", 0, 1, 4'b0010);
`else
            lit("bp_hold", 1, 1, 4'b0001);
`endif
        end
        bus.ready = 1'b1;
        cyc();
`ifdef ROUND_ROBIN_EN
        lit("bp_next", 1, 1, 4'b0000);
`else
        lit("bp_next", 0, 1, 4'b0000);
`endif
        cyc();
        chk("bp_done_valid", int'(bus.valid), 0);

        do_reset();
        bus.req = 4'b1000;
        cyc();
        cyc();
        lit("setclr_g1", 3, 1, 4'b1000);
        bus.req = 4'b0;
        cyc();
        lit("setclr_g2", 3, 1, 4'b0000);
        cyc();
        lit("setclr_done", 3, 0, 4'b0000);

        do_reset();
        bus.req = 4'b1000;
        cyc();
        bus.en = 1'b0;
        cyc();
        lit("noen_g1", 3, 1, 4'b0000);
        cyc();
        lit("noen_done", 3, 0, 4'b0000);
        bus.en = 1'b1;
        bus.req = 4'b0;

        do_reset();
        bus.req = 4'b1111;
        cyc();
        bus.req = 4'b0;
        cyc();
`ifdef ROUND_ROBIN_EN
        lit("mid_g1", 0, 1, 4'b1110);
`else
        lit("mid_g1", 3, 1, 4'b0111);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        lit("mid_rst", 0, 0, 4'b0000);
        cyc();
        lit("mid_quiet1", 0, 0, 4'b0000);
        cyc();
        lit("mid_quiet2", 0, 0, 4'b0000);

        for (int n = 0; n < 3000; n++) begin
            bus.en = ($urandom % 4) != 0;
            bus.req = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0;
            bus.ready = ($urandom % 3) != 0;
            rst = ($urandom % 150) == 0;
            cyc();
        end
        rst = 1'b0;
        cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
